// File: rtl/ascon_pkg.sv
// Shared ASCON control definitions: round-counter constants, finalization
// state encoding and the per-state control word decoder.
package ascon_pkg;

  localparam logic [3:0] P12_START_ROUND = 4'd0;
  localparam logic [3:0] P6_START_ROUND  = 4'd6;
  localparam logic [3:0] LAST_ROUND_P12  = 4'd11;

  typedef enum logic [2:0] {
    FIN_IDLE       = 3'd0,
    FIN_CONF_FINAL = 3'd1,
    FIN_RD0        = 3'd2,
    FIN_RD_MID     = 3'd3,
    FIN_RD_LAST    = 3'd4,
    FIN_TAG_WAIT   = 3'd5
  } fin_state_e;

  typedef struct packed {
    logic en_cpt_perm;
    logic init_p12;
    logic init_p6;
    logic input_mode;
    logic en_reg_state;
    logic en_xor_key_begin;
    logic en_xor_key_final;
    logic en_reg_tag;
    logic tag_valid;
    logic busy;
  } fin_ctrl_t;

  // Moore control word per state; unencoded states decode to all-zero.
  function automatic fin_ctrl_t fin_decode(input fin_state_e st);
    fin_ctrl_t c;
    c = '0;
    case (st)
      FIN_CONF_FINAL: begin
        c.en_cpt_perm = 1'b1;
        c.init_p12    = 1'b1;
        c.busy        = 1'b1;
      end
      FIN_RD0: begin
        c.en_cpt_perm      = 1'b1;
        c.en_reg_state     = 1'b1;
        c.en_xor_key_begin = 1'b1;
        c.busy             = 1'b1;
      end
      FIN_RD_MID: begin
        c.en_cpt_perm  = 1'b1;
        c.en_reg_state = 1'b1;
        c.input_mode   = 1'b1;
        c.busy         = 1'b1;
      end
      FIN_RD_LAST: begin
        c.en_cpt_perm      = 1'b1;
        c.en_reg_state     = 1'b1;
        c.input_mode       = 1'b1;
        c.en_xor_key_final = 1'b1;
        c.en_reg_tag       = 1'b1;
        c.busy             = 1'b1;
      end
      FIN_TAG_WAIT: begin
        c.tag_valid = 1'b1;
        c.busy      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fsm_final.sv
// ASCON-128 finalization controller: key XOR, p12 sequencing, tag latch and
// valid/ack hold. Moore outputs; end_o is the only input-qualified output.
module fsm_final
  import ascon_pkg::*;
#(
  parameter logic [3:0] LAST_ROUND = LAST_ROUND_P12
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] round_i,
  input  logic       tag_ack_i,
  output logic       en_cpt_perm_o,
  output logic       init_p12_o,
  output logic       init_p6_o,
  output logic       input_mode_o,
  output logic       en_reg_state_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_final_o,
  output logic       en_reg_tag_o,
  output logic       tag_valid_o,
  output logic       busy_o,
  output logic       end_o
);

  fin_state_e state_q, state_d;
  fin_ctrl_t  ctrl;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= FIN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FIN_IDLE:       if (start_i) state_d = FIN_CONF_FINAL;
      FIN_CONF_FINAL: state_d = FIN_RD0;
      FIN_RD0:        state_d = FIN_RD_MID;
      // ">=" so a counter that skips past the penultimate round still exits.
      FIN_RD_MID:     if (round_i >= (LAST_ROUND - 4'd1)) state_d = FIN_RD_LAST;
      FIN_RD_LAST:    state_d = FIN_TAG_WAIT;
      FIN_TAG_WAIT:   if (tag_ack_i) state_d = FIN_IDLE;
      default:        state_d = FIN_IDLE;
    endcase
  end

  always_comb begin
    ctrl = fin_decode(state_q);
  end

  assign en_cpt_perm_o      = ctrl.en_cpt_perm;
  assign init_p12_o         = ctrl.init_p12;
  assign init_p6_o          = ctrl.init_p6;
  assign input_mode_o       = ctrl.input_mode;
  assign en_reg_state_o     = ctrl.en_reg_state;
  assign en_xor_key_begin_o = ctrl.en_xor_key_begin;
  assign en_xor_key_final_o = ctrl.en_xor_key_final;
  assign en_reg_tag_o       = ctrl.en_reg_tag;
  assign tag_valid_o        = ctrl.tag_valid;
  assign busy_o             = ctrl.busy;
  assign end_o              = ctrl.tag_valid & tag_ack_i;

endmodule
